// File: rtl/laser_pkg.sv
// Shared definitions for the laser link TX scheduler: FSM state encoding,
// default packet width and serial-link timing constants.
package laser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    localparam int PKT_LENGTH_DEF = 32;
    localparam int CLK_HZ         = 65_000_000;
    localparam int BAUD           = 4800;
    // One bit time at BAUD, expressed as idle clocks between packets
    localparam int CLK_PER_BIT    = (CLK_HZ / BAUD) - 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr_i (wrapping), returning one-hot grant, its index and a valid flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IW = $clog2(NUM_REQ);

    // Scan requests starting at the pointer; first hit wins
    always_comb begin
        logic [IW-1:0] j_s;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j_s     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j_s = IW'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[j_s]) begin
                any_o        = 1'b1;
                grant_o[j_s] = 1'b1;
                idx_o        = j_s;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/laser_tx_scheduler.sv
// Round-robin scheduler sharing one serial laser transmitter among NUM_REQ
// packet sources, with launch acknowledge timeout and an inter-packet idle gap.
module laser_tx_scheduler
    import laser_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int PKT_LENGTH  = PKT_LENGTH_DEF,
    parameter int GAP_CYCLES  = CLK_PER_BIT,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*PKT_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [PKT_LENGTH-1:0]         tx_data,
    output logic                          tx_new_data,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          sent,
    output logic                          err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(max_int(GAP_CYCLES, ACK_TIMEOUT) + 1);

    state_e                state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         ctr_q, ctr_d;
    logic [PKT_LENGTH-1:0] tx_data_q, tx_data_d;
    logic [IW-1:0]         grant_id_q, grant_id_d;
    logic                  new_q, new_d;
    logic                  sent_q, sent_d;
    logic                  err_q, err_d;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic [IW-1:0]         idx_s;
    logic                  any_s;
    logic [PKT_LENGTH-1:0] pkt_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .idx_o   (idx_s),
        .any_o   (any_s)
    );

    // Packet of the current arbitration winner
    always_comb begin
        pkt_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx_s == IW'(i)) begin
                pkt_s = req_data[i*PKT_LENGTH +: PKT_LENGTH];
            end else begin
                pkt_s = pkt_s;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        ctr_d       = ctr_q;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        new_d       = 1'b0;
        sent_d      = 1'b0;
        err_d       = 1'b0;
        req_ready_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_busy && any_s) begin
                    req_ready_s = grant_s;
                    tx_data_d   = pkt_s;
                    grant_id_d  = idx_s;
                    rr_ptr_d    = (int'(idx_s) == NUM_REQ - 1) ? '0 : idx_s + IW'(1);
                    new_d       = 1'b1;
                    state_d     = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                ctr_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ctr_q == CW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ctr_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    sent_d  = 1'b1;
                    ctr_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (ctr_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            ctr_q      <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            new_q      <= 1'b0;
            sent_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            ctr_q      <= ctr_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            new_q      <= new_d;
            sent_q     <= sent_d;
            err_q      <= err_d;
        end
    end

    // Ready is a same-cycle grant; forced low while reset is held
    assign req_ready   = req_ready_s & {NUM_REQ{~rst}};
    assign tx_data     = tx_data_q;
    assign tx_new_data = new_q;
    assign grant_id    = grant_id_q;
    assign sent        = sent_q;
    assign err_timeout = err_q;

endmodule
